cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 92 +++++++++
 tb/tb_cpu_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/EXEC/MEM/WB control sequencer with
// memory-timeout error halt and saturating performance counters.
module cpu_sequencer #(
   parameter int PC_W        = 8,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [8:0]       instr_in,
   input  logic             dec_mem_read,
   input  logic             dec_mem_write,
   input  logic             dec_reg_write,
   input  logic             dec_halt,
   input  logic             branch_taken,
   input  logic [PC_W-1:0]  branch_target,
   input  logic             mem_ack,
   output logic [PC_W-1:0]  pc,
   output logic [8:0]       ir,
   output logic             ir_load,
   output logic             reg_we,
   output logic             mem_req,
   output logic             mem_we,
   output logic             busy,
   output logic             done,
   output logic             mem_err,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);
   localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} state_t;

   state_t          state, state_nxt;
   logic [WT_W-1:0] wait_cnt;
   logic            launch, timeout;

   assign launch  = (state == IDLE || state == HALT) && start;
   // an ack arriving on the last allowed cycle still wins over the timeout
   assign timeout = state == MEM && !mem_ack && wait_cnt == WT_W'(MEM_TIMEOUT - 1);

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HALT: state_nxt = start ? FETCH : state;
         FETCH:      state_nxt = EXEC;
         EXEC:       state_nxt = dec_halt ? HALT : (dec_mem_read || dec_mem_write) ? MEM : WB;
         MEM:        state_nxt = mem_ack ? WB : timeout ? HALT : MEM;
         WB:         state_nxt = FETCH;
         default:    state_nxt = IDLE;
      endcase
   end

   // strobes decode straight from state so an async reset drops them at once
   always_comb begin
      ir_load = state == FETCH;
      busy    = state inside {FETCH, EXEC, MEM, WB};
      done    = state == HALT;
      mem_req = state == MEM;
      mem_we  = state == MEM && dec_mem_write;
      reg_we  = state == WB && dec_reg_write;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc          <= '0;
         ir          <= '0;
         wait_cnt    <= '0;
         mem_err     <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         if (state == FETCH) ir <= instr_in;
         wait_cnt <= state == MEM ? wait_cnt + WT_W'(1) : '0;
         if (launch) begin
            pc          <= '0;
            mem_err     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
         end else begin
            if (state == WB) pc <= branch_taken ? branch_target : pc + PC_W'(1);
            if (timeout) mem_err <= 1'b1;
            if (busy && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (state == WB && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
         end
      end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: runs short programs through cpu_sequencer and scores each
// retired instruction against a queue of expected end-of-instruction results.
module tb_cpu_sequencer;
   logic        clk = 0, reset = 1, start = 0, mem_ack = 0;
   logic [8:0]  instr_in, ir;
   logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_halt, branch_taken;
   logic [7:0]  branch_target, pc;
   logic        ir_load, reg_we, mem_req, mem_we, busy, done, mem_err;
   logic [15:0] cycle_count, instr_count;

   typedef struct {
      logic [7:0] pc;
      int         ic, cc, we, mr, mw;
      logic       err, done;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [8:0] prog [16];
   logic [7:0] tgt [16];
   logic [3:0] fi = 0;
   logic [7:0] mpc;
   logic       active = 0;
   int         total = 0, bad = 0, np, mic, mcc, nwe, nmr, nmw, mc = 0;

   // ir bit map: 8 halt, 7 read, 6 write, 5 reg write, 4 branch, 3:0 ack delay
   assign dec_halt      = ir[8];
   assign dec_mem_read  = ir[7];
   assign dec_mem_write = ir[6];
   assign dec_reg_write = ir[5];
   assign branch_taken  = ir[4];
   assign instr_in      = prog[fi];
   assign branch_target = tgt[fi - 4'd1];

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
      .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
      .dec_reg_write(dec_reg_write), .dec_halt(dec_halt),
      .branch_taken(branch_taken), .branch_target(branch_target), .mem_ack(mem_ack),
      .pc(pc), .ir(ir), .ir_load(ir_load), .reg_we(reg_we), .mem_req(mem_req),
      .mem_we(mem_we), .busy(busy), .done(done), .mem_err(mem_err),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset || (start && !busy)) fi <= 0;
      else if (ir_load) fi <= fi + 4'd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // memory acks on its Nth MEM cycle (N=0: never); non-memory instructions
   // with a nonzero delay field hold a stray ack high outside MEM
   always @(negedge clk)
      if (mem_req) begin
         mc = mc + 1;
         mem_ack = ir[3:0] != 0 && mc == int'(ir[3:0]);
      end else begin
         mc = 0;
         mem_ack = !ir[7] && !ir[6] && ir[3:0] != 0 && busy;
      end

   always @(negedge clk)
      if (reset) active = 0;
      else begin
         if (active && (ir_load || done)) begin
            active = 0;
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("pc", pc, e.pc);
               chk("instr_count", instr_count, e.ic);
               chk("cycle_count", cycle_count, e.cc);
               chk("reg_we_cycles", nwe, e.we);
               chk("mem_req_cycles", nmr, e.mr);
               chk("mem_we_cycles", nmw, e.mw);
               chk("mem_err", mem_err, e.err);
               chk("done", done, e.done);
            end
         end
         if (ir_load) begin
            active = 1;
            nwe = 0; nmr = 0; nmw = 0;
         end
         if (active) begin
            nwe += int'(reg_we);
            nmr += int'(mem_req);
            nmw += int'(mem_we);
         end
      end

   task automatic new_seg();
      np = 0; mpc = 0; mic = 0; mcc = 0;
   endtask

   task automatic add(input logic [8:0] ins, input logic [7:0] t);
      exp_t x;
      int   d = int'(ins[3:0]);
      prog[np] = ins;
      tgt[np]  = t;
      np++;
      x = '{pc:0, ic:0, cc:0, we:0, mr:0, mw:0, err:0, done:0};
      if (ins[8]) begin
         mcc += 2;
         x.done = 1;
      end else if (ins[7] || ins[6]) begin
         if (d == 0) begin
            mcc += 17;
            x.mr = 15; x.mw = ins[6] ? 15 : 0; x.err = 1; x.done = 1;
         end else begin
            mcc += 3 + d;
            x.mr = d; x.mw = ins[6] ? d : 0; x.we = int'(ins[5]);
            mpc = ins[4] ? t : mpc + 8'd1;
            mic++;
         end
      end else begin
         mcc += 3;
         x.we = int'(ins[5]);
         mpc = ins[4] ? t : mpc + 8'd1;
         mic++;
      end
      x.pc = mpc; x.ic = mic; x.cc = mcc;
      sb.push_back(x);
   endtask

   task automatic go();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic wait_sb();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      sb.delete();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin prog[i] = 0; tgt[i] = 0; end
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_strobes", {ir_load, reg_we, mem_req, mem_we}, 0);
      chk("rst_counts", {cycle_count, instr_count}, 0);
      chk("rst_err", mem_err, 0);
      reset = 0;
      repeat (3) @(negedge clk);
      chk("idle_hold", {busy, done}, 0);

      // ADD (stray ack), LW ack@2, SW ack@1, branch to 0x10, HALT
      new_seg();
      add(9'h023, 8'h00); add(9'h0A2, 8'h00); add(9'h041, 8'h00);
      add(9'h010, 8'h10); add(9'h100, 8'h00);
      go();
      repeat (5) @(negedge clk);
      start = 1; @(negedge clk); start = 0;
      wait_sb();

      // restart from HALT: branch to 0xFF, wrap to 0x00, HALT
      new_seg();
      add(9'h030, 8'hFF); add(9'h020, 8'h00); add(9'h100, 8'h00);
      go();
      chk("restart_pc", pc, 0);
      chk("restart_counts", {cycle_count, instr_count}, 0);
      chk("restart_busy", {busy, done}, 2'b10);
      wait_sb();

      // store whose ack never arrives
      new_seg();
      add(9'h060, 8'h00);
      wait_sb_start: go();
      wait_sb();

      // async reset in the middle of a MEM wait
      new_seg();
      prog[0] = 9'h080;
      go();
      chk("err_cleared", mem_err, 0);
      for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
      chk("mem_req_up", mem_req, 1);
      @(posedge clk); #2 reset = 1; #1;
      chk("async_mem_req", mem_req, 0);
      chk("async_busy", busy, 0);
      chk("async_pc_ir", {pc, ir}, 0);
      chk("async_counts", {cycle_count, instr_count}, 0);
      start = 1;
      repeat (3) @(negedge clk);
      chk("start_in_reset", {busy, done}, 0);
      start = 0; reset = 0;
      repeat (3) @(negedge clk);
      chk("post_reset_idle", {busy, done}, 0);

      new_seg();
      add(9'h020, 8'h00); add(9'h100, 8'h00);
      go();
      wait_sb();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
